// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared types and constants for the pipeline control block.
//                - FWD_NONE / FWD_WB / FWD_M : execute-stage operand sources
//                - pctrl_state_t             : multi-cycle sequencer states
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Operand source selectors for the execute stage
    localparam logic [1:0] FWD_NONE = 2'b00;  // register file
    localparam logic [1:0] FWD_WB   = 2'b01;  // write-back result
    localparam logic [1:0] FWD_M    = 2'b10;  // memory-stage result

    // Multi-cycle sequencer
    typedef enum logic [0:0] {
        RUN    = 1'b0,
        MCBUSY = 1'b1
    } pctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : scoreboard
//  Description : One pending-write bit per architectural register.
//                A bit is set when a writing instruction issues and cleared
//                when write-back writes that register; set beats clear.
//  Ports       : clock, reset (async, active low)
//                setEnable/setAddress     - mark register pending
//                clearEnable/clearAddress - write-back retires register
//                readAddress1/2           - lookup addresses
//                readPending1/2           - pending state of those registers
//  Revision    : 1.0 - initial release
// ============================================================================
module scoreboard #(
    parameter int REGNUM       = 16,
    parameter int ADDRESSWIDTH = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    setEnable,
    input  logic [ADDRESSWIDTH-1:0] setAddress,
    input  logic                    clearEnable,
    input  logic [ADDRESSWIDTH-1:0] clearAddress,
    input  logic [ADDRESSWIDTH-1:0] readAddress1,
    input  logic [ADDRESSWIDTH-1:0] readAddress2,
    output logic                    readPending1,
    output logic                    readPending2
);

    logic [REGNUM-1:0] r_pending;
    logic [REGNUM-1:0] w_setMask;
    logic [REGNUM-1:0] w_clearMask;

    assign w_setMask   = setEnable   ? (REGNUM'(1) << setAddress)   : '0;
    assign w_clearMask = clearEnable ? (REGNUM'(1) << clearAddress) : '0;

    // Clear first, then OR in the set so a same-cycle set survives
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clearMask) | w_setMask;
        end
    end

    assign readPending1 = r_pending[readAddress1];
    assign readPending2 = r_pending[readAddress2];

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_ctrl
//  Description : Hazard and sequencing control for a 5-stage pipeline.
//                Bypass mode (FORWARDING=1) forwards M/WB results and stalls
//                one cycle on load-use; stall mode (FORWARDING=0) tracks
//                pending writes in a scoreboard and stalls until they retire.
//                A multi-cycle execute op freezes fetch/decode while busy.
//  Ports       : clock, reset (async, active low)
//                *D  - decode-stage sources, destination, multi-cycle flag
//                *E  - execute-stage sources, load flag, destination, branch
//                *M / *WB - memory and write-back register writes
//                stallF/stallD/flushD/flushE - pipeline register controls
//                data1/2ForwardSelectorE     - execute operand source
//                mcBusy                      - multi-cycle op in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
    import cpu_pkg::*;
#(
    parameter int ADDRESSWIDTH = 4,
    parameter int REGNUM       = 16,
    parameter int MCLATENCY    = 4,
    parameter int FORWARDING   = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ADDRESSWIDTH-1:0] reg1AddressD,
    input  logic [ADDRESSWIDTH-1:0] reg2AddressD,
    input  logic                    useReg1D,
    input  logic                    useReg2D,
    input  logic                    writeEnableDD,
    input  logic [ADDRESSWIDTH-1:0] regDestinationAddressD,
    input  logic                    isMultiD,
    input  logic [ADDRESSWIDTH-1:0] reg1AddressE,
    input  logic [ADDRESSWIDTH-1:0] reg2AddressE,
    input  logic                    isLoadE,
    input  logic [ADDRESSWIDTH-1:0] regDestinationAddressE,
    input  logic                    writeEnableDM,
    input  logic [ADDRESSWIDTH-1:0] regDestinationAddressM,
    input  logic                    writeEnableDWB,
    input  logic [ADDRESSWIDTH-1:0] regDestinationAddressWB,
    input  logic                    takeBranchE,
    output logic                    stallF,
    output logic                    stallD,
    output logic                    flushD,
    output logic                    flushE,
    output logic [1:0]              data1ForwardSelectorE,
    output logic [1:0]              data2ForwardSelectorE,
    output logic                    mcBusy
);

    // Counter value that yields MCLATENCY-1 busy cycles after the issue cycle
    localparam logic [3:0] c_MC_LOAD = 4'(MCLATENCY - 1);

    pctrl_state_t r_state;
    pctrl_state_t w_stateNext;
    logic [3:0]   r_mcCount;
    logic [3:0]   w_mcCountNext;
    logic         w_dataHazard;
    logic         w_issue;
    logic         w_setEnable;

    // ------------------------------------------------------------------------
    // Hazard detection and operand selection, per forwarding mode
    // ------------------------------------------------------------------------
    if (FORWARDING != 0) begin : g_bypass
        logic w_loadUse1;
        logic w_loadUse2;
        logic w_unusedStallMode;

        assign w_loadUse1   = useReg1D && (regDestinationAddressE == reg1AddressD);
        assign w_loadUse2   = useReg2D && (regDestinationAddressE == reg2AddressD);
        assign w_dataHazard = isLoadE && (w_loadUse1 || w_loadUse2);

        // M is the younger result, so it wins over WB for the same register
        always_comb begin
            data1ForwardSelectorE = FWD_NONE;
            data2ForwardSelectorE = FWD_NONE;
            if (reset) begin
                if (writeEnableDM && (regDestinationAddressM == reg1AddressE)) begin
                    data1ForwardSelectorE = FWD_M;
                end else if (writeEnableDWB && (regDestinationAddressWB == reg1AddressE)) begin
                    data1ForwardSelectorE = FWD_WB;
                end
                if (writeEnableDM && (regDestinationAddressM == reg2AddressE)) begin
                    data2ForwardSelectorE = FWD_M;
                end else if (writeEnableDWB && (regDestinationAddressWB == reg2AddressE)) begin
                    data2ForwardSelectorE = FWD_WB;
                end
            end
        end

        // Issue bookkeeping only matters when a scoreboard exists
        assign w_unusedStallMode = ^{writeEnableDD, regDestinationAddressD, w_setEnable};
    end else begin : g_stallMode
        logic w_pending1;
        logic w_pending2;
        logic w_unusedBypassMode;

        scoreboard #(
            .REGNUM       (REGNUM),
            .ADDRESSWIDTH (ADDRESSWIDTH)
        ) u_scoreboard (
            .clock        (clock),
            .reset        (reset),
            .setEnable    (w_setEnable),
            .setAddress   (regDestinationAddressD),
            .clearEnable  (writeEnableDWB),
            .clearAddress (regDestinationAddressWB),
            .readAddress1 (reg1AddressD),
            .readAddress2 (reg2AddressD),
            .readPending1 (w_pending1),
            .readPending2 (w_pending2)
        );

        assign w_dataHazard = (useReg1D && w_pending1) || (useReg2D && w_pending2);

        assign data1ForwardSelectorE = FWD_NONE;
        assign data2ForwardSelectorE = FWD_NONE;

        // Execute/memory stage information is irrelevant without bypassing
        assign w_unusedBypassMode = ^{reg1AddressE, reg2AddressE, isLoadE,
                                      regDestinationAddressE, writeEnableDM,
                                      regDestinationAddressM};
    end

    // ------------------------------------------------------------------------
    // Sequencer state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= RUN;
            r_mcCount <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_mcCount <= w_mcCountNext;
        end
    end

    // The decode instruction moves into execute only when it is neither
    // held in decode nor squashed on its way into execute.
    assign w_issue     = !stallD && !flushE;
    assign w_setEnable = w_issue && writeEnableDD;

    // ------------------------------------------------------------------------
    // Pipeline controls and next state
    // Priority: taken branch, then multi-cycle busy, then data hazard.
    // ------------------------------------------------------------------------
    always_comb begin
        stallF        = 1'b0;
        stallD        = 1'b0;
        flushD        = 1'b0;
        flushE        = 1'b0;
        mcBusy        = 1'b0;
        w_stateNext   = r_state;
        w_mcCountNext = r_mcCount;

        if (reset) begin
            mcBusy = (r_state == MCBUSY);
            if (takeBranchE) begin
                flushD = 1'b1;
                flushE = 1'b1;
            end else if (r_state == MCBUSY) begin
                // E/M/WB are frozen externally via mcBusy, so no bubble here
                stallF = 1'b1;
                stallD = 1'b1;
            end else if (w_dataHazard) begin
                stallF = 1'b1;
                stallD = 1'b1;
                flushE = 1'b1;
            end
        end

        case (r_state)
            RUN: begin
                // A branch sets flushE, which blocks the issue and the start
                if (isMultiD && w_issue) begin
                    w_stateNext   = MCBUSY;
                    w_mcCountNext = c_MC_LOAD;
                end
            end
            MCBUSY: begin
                if (r_mcCount <= 4'd1) begin
                    w_stateNext   = RUN;
                    w_mcCountNext = 4'd0;
                end else begin
                    w_mcCountNext = r_mcCount - 4'd1;
                end
            end
            default: begin
                w_stateNext   = RUN;
                w_mcCountNext = 4'd0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_ctrl
//  Description : Self-checking bench for pipeline_ctrl. One instance in bypass
//                mode and one in scoreboard-stall mode share the stimulus;
//                a behavioural model predicts both every cycle, and directed
//                scenarios pin the model with literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

    localparam int AW    = 4;
    localparam int MCLAT = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] reg1AddressD, reg2AddressD, regDestinationAddressD;
    logic          useReg1D, useReg2D, writeEnableDD, isMultiD;
    logic [AW-1:0] reg1AddressE, reg2AddressE, regDestinationAddressE;
    logic          isLoadE, takeBranchE;
    logic          writeEnableDM, writeEnableDWB;
    logic [AW-1:0] regDestinationAddressM, regDestinationAddressWB;

    logic       stallFF, stallDF, flushDF, flushEF, mcBusyF;
    logic [1:0] sel1F, sel2F;
    logic       stallFS, stallDS, flushDS, flushES, mcBusyS;
    logic [1:0] sel1S, sel2S;

    // Packed view: {stallF, stallD, flushD, flushE, sel1, sel2, mcBusy}
    logic [8:0] outF, outS;
    assign outF = {stallFF, stallDF, flushDF, flushEF, sel1F, sel2F, mcBusyF};
    assign outS = {stallFS, stallDS, flushDS, flushES, sel1S, sel2S, mcBusyS};

    int nChecks = 0;
    int nErrors = 0;

    // Model state: remaining busy cycles per instance, pending registers (stall mode)
    int          remF  = 0;
    int          remS  = 0;
    logic [15:0] pendS = '0;

    always #5 clock = ~clock;

    pipeline_ctrl #(.ADDRESSWIDTH(AW), .REGNUM(16), .MCLATENCY(MCLAT), .FORWARDING(1)) dutF (
        .clock(clock), .reset(reset),
        .reg1AddressD(reg1AddressD), .reg2AddressD(reg2AddressD),
        .useReg1D(useReg1D), .useReg2D(useReg2D),
        .writeEnableDD(writeEnableDD), .regDestinationAddressD(regDestinationAddressD),
        .isMultiD(isMultiD),
        .reg1AddressE(reg1AddressE), .reg2AddressE(reg2AddressE),
        .isLoadE(isLoadE), .regDestinationAddressE(regDestinationAddressE),
        .writeEnableDM(writeEnableDM), .regDestinationAddressM(regDestinationAddressM),
        .writeEnableDWB(writeEnableDWB), .regDestinationAddressWB(regDestinationAddressWB),
        .takeBranchE(takeBranchE),
        .stallF(stallFF), .stallD(stallDF), .flushD(flushDF), .flushE(flushEF),
        .data1ForwardSelectorE(sel1F), .data2ForwardSelectorE(sel2F), .mcBusy(mcBusyF)
    );

    pipeline_ctrl #(.ADDRESSWIDTH(AW), .REGNUM(16), .MCLATENCY(MCLAT), .FORWARDING(0)) dutS (
        .clock(clock), .reset(reset),
        .reg1AddressD(reg1AddressD), .reg2AddressD(reg2AddressD),
        .useReg1D(useReg1D), .useReg2D(useReg2D),
        .writeEnableDD(writeEnableDD), .regDestinationAddressD(regDestinationAddressD),
        .isMultiD(isMultiD),
        .reg1AddressE(reg1AddressE), .reg2AddressE(reg2AddressE),
        .isLoadE(isLoadE), .regDestinationAddressE(regDestinationAddressE),
        .writeEnableDM(writeEnableDM), .regDestinationAddressM(regDestinationAddressM),
        .writeEnableDWB(writeEnableDWB), .regDestinationAddressWB(regDestinationAddressWB),
        .takeBranchE(takeBranchE),
        .stallF(stallFS), .stallD(stallDS), .flushD(flushDS), .flushE(flushES),
        .data1ForwardSelectorE(sel1S), .data2ForwardSelectorE(sel2S), .mcBusy(mcBusyS)
    );

    task automatic chk(input string name, input logic [8:0] got, input logic [8:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
        end
    endtask

    // Expected outputs from the current inputs and the model state
    function automatic logic [8:0] modelOut(input bit bypass, input int rem, input logic [15:0] pend);
        logic       hz;
        logic [1:0] s1, s2;
        logic [3:0] ctl;
        if (!reset) return 9'd0;
        s1 = 2'b00;
        s2 = 2'b00;
        if (bypass) begin
            hz = isLoadE && ((useReg1D && regDestinationAddressE == reg1AddressD) ||
                             (useReg2D && regDestinationAddressE == reg2AddressD));
            if (writeEnableDM && regDestinationAddressM == reg1AddressE)        s1 = 2'b10;
            else if (writeEnableDWB && regDestinationAddressWB == reg1AddressE) s1 = 2'b01;
            if (writeEnableDM && regDestinationAddressM == reg2AddressE)        s2 = 2'b10;
            else if (writeEnableDWB && regDestinationAddressWB == reg2AddressE) s2 = 2'b01;
        end else begin
            hz = (useReg1D && pend[reg1AddressD]) || (useReg2D && pend[reg2AddressD]);
        end
        // ctl = {stallF, stallD, flushD, flushE}
        if (takeBranchE)  ctl = 4'b0011;
        else if (rem > 0) ctl = 4'b1100;
        else if (hz)      ctl = 4'b1101;
        else              ctl = 4'b0000;
        return {ctl, s1, s2, (rem > 0)};
    endfunction

    // Per-cycle compare, then advance the model across the coming rising edge
    always @(negedge clock) begin
        logic [8:0] eF, eS;
        logic       issF, issS;
        eF = modelOut(1'b1, remF, 16'h0);
        eS = modelOut(1'b0, remS, pendS);
        chk("cycle_bypass", outF, eF);
        chk("cycle_stall", outS, eS);
        if (!reset) begin
            remF  = 0;
            remS  = 0;
            pendS = '0;
        end else begin
            issF = !eF[7] && !eF[5];
            issS = !eS[7] && !eS[5];
            if (remF > 0) remF = remF - 1;
            else if (isMultiD && issF) remF = MCLAT - 1;
            if (remS > 0) remS = remS - 1;
            else if (isMultiD && issS) remS = MCLAT - 1;
            if (writeEnableDWB) pendS[regDestinationAddressWB] = 1'b0;
            if (issS && writeEnableDD) pendS[regDestinationAddressD] = 1'b1;
        end
    end

    task automatic idleInputs();
        reg1AddressD = '0; reg2AddressD = '0; regDestinationAddressD = '0;
        useReg1D = 1'b0; useReg2D = 1'b0; writeEnableDD = 1'b0; isMultiD = 1'b0;
        reg1AddressE = '0; reg2AddressE = '0; regDestinationAddressE = '0;
        isLoadE = 1'b0; takeBranchE = 1'b0;
        writeEnableDM = 1'b0; writeEnableDWB = 1'b0;
        regDestinationAddressM = '0; regDestinationAddressWB = '0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        idleInputs();

        // Reset: outputs forced low even with active-looking inputs
        step();
        takeBranchE = 1'b1; isLoadE = 1'b1; useReg1D = 1'b1;
        writeEnableDM = 1'b1; regDestinationAddressM = 4'd3; reg1AddressE = 4'd3;
        #2 chk("reset_outs_bypass", outF, 9'd0);
        chk("reset_outs_stall", outS, 9'd0);
        step(); idleInputs();
        step(); reset = 1'b1;

        // Forwarding: M match, M and WB both match, WB only
        step(); idleInputs();
        reg1AddressE = 4'd3; writeEnableDM = 1'b1; regDestinationAddressM = 4'd3;
        #2 chk("fwd_m", outF, {4'b0000, 2'b10, 2'b00, 1'b0});
        step();
        writeEnableDWB = 1'b1; regDestinationAddressWB = 4'd3;
        #2 chk("fwd_m_over_wb", outF, {4'b0000, 2'b10, 2'b00, 1'b0});
        step();
        writeEnableDM = 1'b0; reg2AddressE = 4'd3;
        #2 chk("fwd_wb_both", outF, {4'b0000, 2'b01, 2'b01, 1'b0});
        chk("fwd_stallmode_zero", outS, 9'd0);

        // Load-use on r5: one bubble, then clear
        step(); idleInputs();
        isLoadE = 1'b1; regDestinationAddressE = 4'd5; useReg1D = 1'b1; reg1AddressD = 4'd5;
        #2 chk("loaduse_stall", outF, {4'b1101, 4'b0000, 1'b0});
        step();
        isLoadE = 1'b0;
        #2 chk("loaduse_release", outF, 9'd0);

        // Taken branch during a load-use hazard
        step();
        isLoadE = 1'b1; takeBranchE = 1'b1;
        #2 chk("branch_over_loaduse", outF, {4'b0011, 4'b0000, 1'b0});

        // Stall mode: write r7 issues, reader stalls until WB writes r7
        step(); idleInputs();
        writeEnableDD = 1'b1; regDestinationAddressD = 4'd7;
        #2 chk("sb_issue", outS, 9'd0);
        step(); idleInputs();
        useReg1D = 1'b1; reg1AddressD = 4'd7;
        #2 chk("sb_stall_0", outS, {4'b1101, 4'b0000, 1'b0});
        step();
        #2 chk("sb_stall_1", outS, {4'b1101, 4'b0000, 1'b0});
        step();
        writeEnableDWB = 1'b1; regDestinationAddressWB = 4'd7;
        #2 chk("sb_stall_wb_cycle", outS, {4'b1101, 4'b0000, 1'b0});
        step();
        writeEnableDWB = 1'b0;
        #2 chk("sb_release", outS, 9'd0);

        // Multi-cycle op: three busy cycles, RUN on the fourth
        step(); idleInputs();
        isMultiD = 1'b1;
        #2 chk("mc_issue", outF, 9'd0);
        for (int i = 1; i <= 3; i++) begin
            step();
            isMultiD = 1'b0;
            #2 chk($sformatf("mc_busy_f_%0d", i), outF, {4'b1100, 4'b0000, 1'b1});
            chk($sformatf("mc_busy_s_%0d", i), outS, {4'b1100, 4'b0000, 1'b1});
        end
        step();
        #2 chk("mc_done_f", outF, 9'd0);
        chk("mc_done_s", outS, 9'd0);

        // Reset asserted during the second busy cycle
        step(); idleInputs();
        isMultiD = 1'b1;
        step();
        isMultiD = 1'b0;
        step();
        writeEnableDM = 1'b1; regDestinationAddressM = 4'd2; reg1AddressE = 4'd2;
        #2 chk("mc2_busy_before_reset", outF, {4'b1100, 4'b1000, 1'b1});
        reset = 1'b0;
        #1 chk("reset_async_f", outF, 9'd0);
        chk("reset_async_s", outS, 9'd0);
        step(); idleInputs();
        step(); reset = 1'b1;
        #2 chk("post_reset_f", outF, 9'd0);
        chk("post_reset_s", outS, 9'd0);
        step();
        #2 chk("post_reset_edge_f", outF, 9'd0);
        chk("post_reset_edge_s", outS, 9'd0);

        // Randomized traffic over a small register window to provoke hazards
        for (int c = 0; c < 3000; c++) begin
            step();
            reg1AddressD           = 4'($urandom_range(0, 7));
            reg2AddressD           = 4'($urandom_range(0, 7));
            regDestinationAddressD = 4'($urandom_range(0, 7));
            useReg1D               = 1'($urandom_range(0, 1));
            useReg2D               = 1'($urandom_range(0, 1));
            writeEnableDD          = ($urandom_range(0, 2) != 0);
            isMultiD               = ($urandom_range(0, 9) == 0);
            reg1AddressE           = 4'($urandom_range(0, 7));
            reg2AddressE           = 4'($urandom_range(0, 7));
            regDestinationAddressE = 4'($urandom_range(0, 7));
            isLoadE                = ($urandom_range(0, 2) == 0);
            writeEnableDM          = 1'($urandom_range(0, 1));
            regDestinationAddressM = 4'($urandom_range(0, 7));
            writeEnableDWB         = 1'($urandom_range(0, 1));
            regDestinationAddressWB = 4'($urandom_range(0, 7));
            // Execute is frozen while a multi-cycle op runs, so no branch resolves then
            takeBranchE            = (remF == 0) && (remS == 0) && ($urandom_range(0, 9) == 0);
        end

        step(); idleInputs();
        #2;
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
`default_nettype wire
